// File: rtl/axi_excl_pkg.sv
// Shared definitions for the AXI exclusive-access monitor: entry layout,
// legal-exclusive size check and the 128-byte reservation granule.
package axi_excl_pkg;

    localparam int MON_ADDR_W  = 64;
    localparam int MON_ID_W    = 16;
    localparam int GRANULE_LSB = 7;

    // Address and ID are held zero-extended so the layout is independent of bus widths.
    typedef struct packed {
        logic                  valid;
        logic [MON_ID_W-1:0]   id;
        logic [MON_ADDR_W-1:0] addr;
        logic [2:0]            size;
        logic [7:0]            len;
    } mon_entry_t;

    // Only addr[6:0] matters: a legal burst never spans more than 128 bytes.
    function automatic logic excl_legal(input logic [7:0] len,
                                        input logic [2:0] size,
                                        input logic [6:0] addr_lo);
        logic [15:0] bytes;
        bytes = ({8'd0, len} + 16'd1) << size;
        if (bytes > 16'd128)
            return 1'b0;
        if ((bytes & (bytes - 16'd1)) != 16'd0)
            return 1'b0;
        return ((addr_lo & (bytes[6:0] - 7'd1)) == 7'd0);
    endfunction

endpackage

// File: rtl/axi_excl_rsp_fifo.sv
// Result FIFO between the exclusive-write decision and the BRESP stage.
module axi_excl_rsp_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             valid,
    output logic             full
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign valid   = (count != '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);
    // Storage is not reset, so the head is masked to keep outputs clean while empty.
    assign rdata   = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/axi_excl_monitor.sv
// AXI exclusive-access monitor: arms reservations on exclusive reads and
// decides EXOKAY/OKAY for exclusive writes, queued for the BRESP stage.
module axi_excl_monitor
    import axi_excl_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 4,
    parameter int NUM_MON    = 4,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  ar_fire,
    input  logic                  ar_lock,
    input  logic [ID_WIDTH-1:0]   ar_id,
    input  logic [ADDR_WIDTH-1:0] ar_addr,
    input  logic [7:0]            ar_len,
    input  logic [2:0]            ar_size,
    input  logic                  aw_fire,
    input  logic                  aw_lock,
    input  logic [ID_WIDTH-1:0]   aw_id,
    input  logic [ADDR_WIDTH-1:0] aw_addr,
    input  logic [7:0]            aw_len,
    input  logic [2:0]            aw_size,
    output logic                  rsp_valid,
    output logic [ID_WIDTH-1:0]   rsp_id,
    output logic                  rsp_exokay,
    input  logic                  rsp_ready,
    output logic                  rsp_full,
    output logic                  overflow
);
    localparam int IW = $clog2(NUM_MON);

    mon_entry_t            mon     [NUM_MON];
    mon_entry_t            mon_nxt [NUM_MON];
    logic [IW-1:0]         rr;
    logic [IW-1:0]         rr_nxt;
    logic [MON_ADDR_W-1:0] aw_addr_ext;
    logic [MON_ADDR_W-1:0] ar_addr_ext;
    logic                  aw_excl;
    logic                  wr_hit;
    logic                  wr_pass;
    logic                  rd_arm;
    logic                  own_hit;
    logic [IW-1:0]         own_idx;
    logic                  free_found;
    logic [IW-1:0]         free_idx;
    logic [IW-1:0]         sel;

    assign aw_addr_ext = MON_ADDR_W'(aw_addr);
    assign ar_addr_ext = MON_ADDR_W'(ar_addr);
    assign aw_excl     = aw_fire && aw_lock;
    assign rd_arm      = ar_fire && ar_lock && excl_legal(ar_len, ar_size, ar_addr[6:0]);

    always_comb begin
        wr_hit = 1'b0;
        for (int i = 0; i < NUM_MON; i++) begin
            if (mon[i].valid && mon[i].id == MON_ID_W'(aw_id) && mon[i].addr == aw_addr_ext &&
                mon[i].size == aw_size && mon[i].len == aw_len)
                wr_hit = 1'b1;
        end
    end

    assign wr_pass = excl_legal(aw_len, aw_size, aw_addr[6:0]) && wr_hit;

    // Write invalidation is applied first so a coincident read re-arms its own entry.
    always_comb begin
        mon_nxt    = mon;
        rr_nxt     = rr;
        own_hit    = 1'b0;
        own_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        sel        = '0;
        if (aw_fire && (!aw_lock || wr_pass)) begin
            for (int i = 0; i < NUM_MON; i++) begin
                if (mon[i].addr[MON_ADDR_W-1:GRANULE_LSB] == aw_addr_ext[MON_ADDR_W-1:GRANULE_LSB])
                    mon_nxt[i].valid = 1'b0;
            end
        end
        for (int i = 0; i < NUM_MON; i++) begin
            if (!own_hit && mon_nxt[i].valid && mon_nxt[i].id == MON_ID_W'(ar_id)) begin
                own_hit = 1'b1;
                own_idx = IW'(i);
            end
        end
        for (int i = NUM_MON - 1; i >= 0; i--) begin
            if (!mon_nxt[i].valid) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
        if (rd_arm) begin
            if (own_hit)
                sel = own_idx;
            else if (free_found)
                sel = free_idx;
            else begin
                sel    = rr;
                rr_nxt = (rr == IW'(NUM_MON - 1)) ? '0 : rr + 1'b1;
            end
            mon_nxt[sel].valid = 1'b1;
            mon_nxt[sel].id    = MON_ID_W'(ar_id);
            mon_nxt[sel].addr  = ar_addr_ext;
            mon_nxt[sel].size  = ar_size;
            mon_nxt[sel].len   = ar_len;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < NUM_MON; i++)
                mon[i].valid <= 1'b0;
            rr       <= '0;
            overflow <= 1'b0;
        end else begin
            mon <= mon_nxt;
            rr  <= rr_nxt;
            if (aw_excl && rsp_full && !(rsp_valid && rsp_ready))
                overflow <= 1'b1;
        end
    end

    axi_excl_rsp_fifo #(
        .WIDTH (ID_WIDTH + 1),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (aclk),
        .rst   (areset),
        .push  (aw_excl),
        .wdata ({aw_id, wr_pass}),
        .pop   (rsp_ready),
        .rdata ({rsp_id, rsp_exokay}),
        .valid (rsp_valid),
        .full  (rsp_full)
    );

endmodule

// File: tb/tb_axi_excl_monitor.sv
// Directed bench for axi_excl_monitor with hand-computed expectations.
module tb_axi_excl_monitor;

    logic        aclk = 1'b0;
    logic        areset;
    logic        ar_fire, ar_lock, aw_fire, aw_lock;
    logic [3:0]  ar_id, aw_id;
    logic [15:0] ar_addr, aw_addr;
    logic [7:0]  ar_len, aw_len;
    logic [2:0]  ar_size, aw_size;
    logic        rsp_valid, rsp_exokay, rsp_ready, rsp_full, overflow;
    logic [3:0]  rsp_id;

    int tests = 0;
    int fails = 0;

    axi_excl_monitor #(
        .ADDR_WIDTH (16),
        .ID_WIDTH   (4),
        .NUM_MON    (4),
        .RSP_DEPTH  (4)
    ) dut (
        .aclk       (aclk),
        .areset     (areset),
        .ar_fire    (ar_fire),
        .ar_lock    (ar_lock),
        .ar_id      (ar_id),
        .ar_addr    (ar_addr),
        .ar_len     (ar_len),
        .ar_size    (ar_size),
        .aw_fire    (aw_fire),
        .aw_lock    (aw_lock),
        .aw_id      (aw_id),
        .aw_addr    (aw_addr),
        .aw_len     (aw_len),
        .aw_size    (aw_size),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_exokay (rsp_exokay),
        .rsp_ready  (rsp_ready),
        .rsp_full   (rsp_full),
        .overflow   (overflow)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
        ar_fire   = 1'b0;
        ar_lock   = 1'b0;
        aw_fire   = 1'b0;
        aw_lock   = 1'b0;
        rsp_ready = 1'b0;
    endtask

    task automatic set_ar(input logic [3:0] id, input logic [15:0] addr,
                          input logic [7:0] len, input logic [2:0] size);
        ar_fire = 1'b1; ar_lock = 1'b1;
        ar_id = id; ar_addr = addr; ar_len = len; ar_size = size;
    endtask

    task automatic set_aw(input logic lock, input logic [3:0] id, input logic [15:0] addr,
                          input logic [7:0] len, input logic [2:0] size);
        aw_fire = 1'b1; aw_lock = lock;
        aw_id = id; aw_addr = addr; aw_len = len; aw_size = size;
    endtask

    task automatic pop_head();
        rsp_ready = 1'b1;
        tick();
    endtask

    initial begin
        logic [3:0] drain_ids [4];
        drain_ids = '{4'd2, 4'd3, 4'd4, 4'd6};
        ar_fire = 0; ar_lock = 0; ar_id = 0; ar_addr = 0; ar_len = 0; ar_size = 0;
        aw_fire = 0; aw_lock = 0; aw_id = 0; aw_addr = 0; aw_len = 0; aw_size = 0;
        rsp_ready = 0;
        areset = 1'b1;
        tick();
        tick();
        check("rst_valid",  rsp_valid,  0);
        check("rst_full",   rsp_full,   0);
        check("rst_ovf",    overflow,   0);
        check("rst_id",     rsp_id,     0);
        check("rst_exokay", rsp_exokay, 0);
        areset = 1'b0;

        // Basic exclusive pair, one-cycle decision latency.
        set_ar(4'd3, 16'h0040, 8'd0, 3'd3);
        tick();
        set_aw(1'b1, 4'd3, 16'h0040, 8'd0, 3'd3);
        check("pair_pre_valid", rsp_valid, 0);
        tick();
        check("pair_valid",  rsp_valid,  1);
        check("pair_id",     rsp_id,     3);
        check("pair_exokay", rsp_exokay, 1);
        pop_head();
        check("pair_popped", rsp_valid, 0);

        // Normal write in same 128-byte granule kills the reservation.
        set_ar(4'd1, 16'h0100, 8'd0, 3'd3);
        tick();
        set_aw(1'b0, 4'd0, 16'h0178, 8'd0, 3'd3);
        tick();
        check("norm_nopush", rsp_valid, 0);
        set_aw(1'b1, 4'd1, 16'h0100, 8'd0, 3'd3);
        tick();
        check("gran_id",     rsp_id,     1);
        check("gran_exokay", rsp_exokay, 0);
        pop_head();

        // Five IDs into four entries: ID4 replaces entry 0 via round-robin.
        for (int i = 0; i < 5; i++) begin
            set_ar(4'(i), 16'(16'h0200 * (i + 1)), 8'd0, 3'd3);
            tick();
        end
        set_aw(1'b1, 4'd0, 16'h0200, 8'd0, 3'd3);
        tick();
        check("rr_id0_exokay", rsp_exokay, 0);
        pop_head();
        set_aw(1'b1, 4'd4, 16'h0A00, 8'd0, 3'd3);
        tick();
        check("rr_id4_exokay", rsp_exokay, 1);
        pop_head();
        set_aw(1'b1, 4'd1, 16'h0400, 8'd0, 3'd3);
        tick();
        check("rr_id1_exokay", rsp_exokay, 1);
        pop_head();

        // Misaligned exclusive read must not arm or disturb ID2's entry at 0x0600.
        set_ar(4'd2, 16'h0004, 8'd0, 3'd3);
        tick();
        set_aw(1'b1, 4'd2, 16'h0004, 8'd0, 3'd3);
        tick();
        check("misal_id",     rsp_id,     2);
        check("misal_exokay", rsp_exokay, 0);
        pop_head();
        set_aw(1'b1, 4'd2, 16'h0600, 8'd0, 3'd3);
        tick();
        check("misal_keep_exokay", rsp_exokay, 1);
        pop_head();

        // 3-byte read is not a power of two; ID3's entry at 0x0800 survives.
        set_ar(4'd3, 16'h0800, 8'd2, 3'd0);
        tick();
        set_aw(1'b1, 4'd3, 16'h0800, 8'd0, 3'd3);
        tick();
        check("npow2_keep_exokay", rsp_exokay, 1);
        pop_head();

        // 128-byte aligned burst is the largest legal exclusive.
        set_ar(4'd5, 16'h0080, 8'd15, 3'd3);
        tick();
        set_aw(1'b1, 4'd5, 16'h0080, 8'd15, 3'd3);
        tick();
        check("b128_id",     rsp_id,     5);
        check("b128_exokay", rsp_exokay, 1);
        pop_head();

        // Fill the FIFO, overflow on the fifth, then push+pop while full.
        for (int i = 1; i <= 4; i++) begin
            set_aw(1'b1, 4'(i), 16'h0040, 8'd0, 3'd3);
            tick();
        end
        check("fill_full", rsp_full, 1);
        check("fill_ovf",  overflow, 0);
        set_aw(1'b1, 4'd5, 16'h0040, 8'd0, 3'd3);
        tick();
        check("ovf_set",     overflow, 1);
        check("ovf_full",    rsp_full, 1);
        check("ovf_head_id", rsp_id,   1);
        set_aw(1'b1, 4'd6, 16'h0040, 8'd0, 3'd3);
        rsp_ready = 1'b1;
        tick();
        check("pp_full",    rsp_full, 1);
        check("pp_head_id", rsp_id,   2);
        check("pp_ovf",     overflow, 1);
        for (int i = 0; i < 4; i++) begin
            check("drain_id", rsp_id, drain_ids[i]);
            pop_head();
        end
        check("drain_empty", rsp_valid, 0);
        check("drain_full",  rsp_full,  0);

        // Reset clears overflow and discards armed reservations.
        areset = 1'b1;
        tick();
        areset = 1'b0;
        check("rst2_ovf", overflow, 0);
        set_ar(4'd7, 16'h0300, 8'd0, 3'd3);
        tick();
        areset = 1'b1;
        tick();
        areset = 1'b0;
        set_aw(1'b1, 4'd7, 16'h0300, 8'd0, 3'd3);
        tick();
        check("rst_arm_id",     rsp_id,     7);
        check("rst_arm_exokay", rsp_exokay, 0);
        check("rst_arm_ovf",    overflow,   0);
        pop_head();

        // Coincident read and same-granule normal write: the read wins.
        set_ar(4'd8, 16'h0300, 8'd0, 3'd3);
        set_aw(1'b0, 4'd0, 16'h0300, 8'd0, 3'd3);
        tick();
        check("coin_nopush", rsp_valid, 0);
        set_aw(1'b1, 4'd8, 16'h0300, 8'd0, 3'd3);
        tick();
        check("coin_id",     rsp_id,     8);
        check("coin_exokay", rsp_exokay, 1);
        pop_head();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi_excl_monitor.md
AXI_EXCL_MONITOR -- requirements
Module: axi_excl_monitor

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, AXI address width.
REQ-002 SHALL have parameter ID_WIDTH, default 4, AR/AW ID width.
REQ-003 SHALL have parameter NUM_MON, default 4, number of exclusive monitor entries (2..16).
REQ-004 SHALL have parameter RSP_DEPTH, default 4, exclusive-result FIFO depth (power of 2).
REQ-005 SHALL have port aclk, input, 1, sole clock; all logic on rising edge.
REQ-006 SHALL have port areset, input, 1, synchronous active-high reset.
REQ-007 SHALL have ports ar_fire/ar_lock/ar_id/ar_addr/ar_len/ar_size, inputs, 1/1/ID_WIDTH/ADDR_WIDTH/8/3, the observed AR handshake and its attributes.
REQ-008 SHALL have ports aw_fire/aw_lock/aw_id/aw_addr/aw_len/aw_size, inputs, 1/1/ID_WIDTH/ADDR_WIDTH/8/3, the observed AW handshake and its attributes.
REQ-009 SHALL have ports rsp_valid, rsp_id, rsp_exokay, outputs, 1/ID_WIDTH/1, the exclusive-write result for the BRESP stage (1 = EXOKAY, 0 = OKAY).
REQ-010 SHALL have port rsp_ready, input, 1, the BRESP stage consumes the FIFO head.
REQ-011 SHALL have port rsp_full, output, 1, FIFO full; the subordinate SHALL gate awready with it.
REQ-012 SHALL have port overflow, output, 1, sticky error: exclusive aw_fire while rsp_full.

Function
REQ-013 SHALL compute bytes = (len+1) << size; a transaction is legal-exclusive iff bytes is a power of 2, bytes <= 128, and addr is aligned to bytes.
REQ-014 SHALL, on ar_fire && ar_lock && legal, arm the entry holding ar_id (or allocate one) with addr, size, len; valid <= 1.
REQ-015 SHALL allocate the lowest-index invalid entry; if none is invalid, replace the entry indicated by a round-robin pointer, which then increments modulo NUM_MON.
REQ-016 SHALL NOT arm any entry for an illegal exclusive read or a non-exclusive read.
REQ-017 SHALL, on aw_fire && aw_lock, pass iff legal and a valid entry with ID == aw_id has addr, size and len equal to the write's.
REQ-018 SHALL push {aw_id, pass} into the result FIFO for every exclusive aw_fire; non-exclusive writes push nothing.
REQ-019 SHALL, on any aw_fire that is non-exclusive or is an exclusive pass, invalidate every entry whose addr[ADDR_WIDTH-1:7] equals aw_addr[ADDR_WIDTH-1:7] (128-byte granule).
REQ-020 SHALL leave all entries unchanged on an exclusive fail.
REQ-021 SHALL, when ar_fire and aw_fire coincide, evaluate the write against pre-cycle state, apply its invalidation, then apply the read arm, so the read wins for its own entry.
REQ-022 SHALL have a one-cycle decision latency: rsp_valid rises the cycle after the exclusive aw_fire when the FIFO was empty.
REQ-023 SHALL hold the FIFO head stable while rsp_valid && !rsp_ready; pop on rsp_valid && rsp_ready.
REQ-024 SHALL allow simultaneous push and pop when full; the push is accepted and rsp_full stays 1.
REQ-025 SHALL drop the push, leave the FIFO unchanged and set overflow on exclusive aw_fire with rsp_full=1 and no pop that cycle.
REQ-026 SHALL assert rsp_full combinationally from the FIFO count == RSP_DEPTH.

Reset
REQ-027 SHALL, on areset=1 at a clock edge, clear all entry valid bits, the round-robin pointer, the FIFO pointers and count, and overflow.
REQ-028 SHALL drive rsp_valid=0, rsp_full=0, overflow=0, rsp_id=0, rsp_exokay=0 during and after reset.
REQ-029 SHALL discard in-flight exclusive state on mid-operation reset; a subsequent exclusive write without a new read fails.

Structure
REQ-030 SHALL place the monitor-entry struct, the legal-exclusive size function and the 128-byte granule constant in the shared package axi_excl_pkg.
REQ-031 SHALL implement the result FIFO as the sub-module axi_excl_rsp_fifo; monitor entries stay inline.

Verification
REQ-032 SHALL cover: exclusive read ID3 addr 0x0040 len0 size3, then exclusive write ID3 same -> rsp_id=3, rsp_exokay=1 one cycle later.
REQ-033 SHALL cover: exclusive read ID1 0x0100, normal write 0x0178, then exclusive write ID1 0x0100 -> rsp_exokay=0.
REQ-034 SHALL cover: exclusive reads ID0..ID4 with NUM_MON=4, then exclusive write ID0 -> fail (entry 0 replaced); write ID4 -> pass.
REQ-035 SHALL cover: exclusive read addr 0x0004 size3 (misaligned), then matching write -> rsp_exokay=0, no entry armed.
REQ-036 SHALL cover: 5 exclusive writes with rsp_ready=0, RSP_DEPTH=4 -> rsp_full=1 after 4, overflow=1 on 5th; head unchanged.
REQ-037 SHALL cover: armed entry, areset pulse, matching exclusive write -> rsp_exokay=0, overflow=0.
